// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: NMASTERS request ports share one slave port.
// Grants come only from registered state so masters may drive strobes combinationally from m_ack.
module bus_arbiter #(
  parameter int NMASTERS = 4
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NMASTERS-1:0]      m_req,
  output logic [NMASTERS-1:0]      m_ack,
  input  logic [32*NMASTERS-1:0]   m_addr,
  input  logic [32*NMASTERS-1:0]   m_wdata,
  input  logic [NMASTERS-1:0]      m_rd,
  input  logic [NMASTERS-1:0]      m_wr,
  output logic [31:0]              m_rdata,
  output logic [NMASTERS-1:0]      m_ready,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic                     s_rd,
  output logic                     s_wr,
  input  logic [31:0]              s_rdata,
  input  logic                     s_ready
);

  localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [IW-1:0] last_reg, last_next;
  logic [IW-1:0] pick_base, pick_idx, cand;
  logic          pick_valid;
  logic          owner_req;

  logic [31:0] addr_arr  [NMASTERS];
  logic [31:0] wdata_arr [NMASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NMASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[32*gi +: 32];
      assign wdata_arr[gi] = m_wdata[32*gi +: 32];
    end
  endgenerate

  assign owner_req = m_req[owner_reg];

  // On release the search starts after the releasing owner, so it only wins when nobody else asks.
  assign pick_base = (state_reg == GRANT) ? owner_reg : last_reg;

  // Descending scan: the smallest offset from pick_base is assigned last and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NMASTERS; k >= 1; k--) begin
      cand = IW'((int'(pick_base) + k) % NMASTERS);
      if (m_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= IW'(NMASTERS - 1);
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          owner_next = pick_idx;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          last_next = owner_reg;
          if (pick_valid) begin
            owner_next = pick_idx;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_ack   = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_rd    = 1'b0;
    s_wr    = 1'b0;
    if (state_reg == GRANT) begin
      m_ack[owner_reg] = 1'b1;
      if (owner_req) begin
        s_addr  = addr_arr[owner_reg];
        s_wdata = wdata_arr[owner_reg];
        s_rd    = m_rd[owner_reg];
        s_wr    = m_wr[owner_reg];
      end
    end
  end

  assign m_ready = m_ack & {NMASTERS{s_ready}};
  // Read data is a pass-through, forced to zero while reset is held.
  assign m_rdata = rst_b ? s_rdata : '0;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NMASTERS, default 4, SHALL set the number of requesting ports on the master side (2..8); port 0 is the ICache and port 1 is the DCache.
REQ-002 clk  input  1  the only clock; all state SHALL change on its rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 m_req  input  NMASTERS  per-master bus request, held for the whole transaction (a whole 16-word cache fill counts as one transaction).
REQ-005 m_ack  output  NMASTERS  per-master grant, one-hot or zero.
REQ-006 m_addr  input  32*NMASTERS  per-master address; master i occupies bits [32i+31:32i].
REQ-007 m_wdata  input  32*NMASTERS  per-master write data, packed the same way as m_addr.
REQ-008 m_rd, m_wr  input  NMASTERS each  per-master read and write strobes.
REQ-009 m_rdata  output  32  read data, broadcast to all masters.
REQ-010 m_ready  output  NMASTERS  per-master data-ready signal.
REQ-011 s_addr, s_wdata  output  32 each  slave address and write data.
REQ-012 s_rd, s_wr  output  1 each  slave read and write strobes.
REQ-013 s_rdata  input  32  slave read data.
REQ-014 s_ready  input  1  slave ready; a beat completes on any clock edge where s_ready=1 and s_rd or s_wr is 1.

Function
REQ-015 State SHALL be a two-state FSM, IDLE and GRANT, plus a registered owner index and a registered last-owner index.
REQ-016 m_ack SHALL be decoded only from registered state: m_ack[owner]=1 in GRANT, and all zeros in IDLE.
REQ-017 Rationale for REQ-016: masters drive their strobes combinationally from ack.
REQ-018 Round-robin pick: search m_req starting at last_owner+1, modulo NMASTERS, and select the first set bit.
REQ-019 IDLE -> GRANT: if any m_req bit is 1, the picked master becomes owner at the next edge; otherwise stay in IDLE.
REQ-020 Grant latency from request SHALL be exactly 1 cycle when the bus is free.
REQ-021 GRANT hold: while m_req[owner]=1, owner SHALL NOT change; there is no tenure limit.
REQ-022 GRANT release: when m_req[owner]=0, last_owner SHALL take the value of owner.
REQ-022a At the same edge as REQ-022, if another request is pending, the FSM SHALL stay in GRANT with the new pick (zero bubble cycles); otherwise it SHALL go to IDLE.
REQ-023 Re-arbitration on release SHALL exclude the releasing master: it is picked only if no other master requests.
REQ-024 Slave mux in GRANT: s_addr, s_wdata, s_rd and s_wr SHALL equal the owner's signals, gated by m_req[owner].
REQ-024a In IDLE, or when m_req[owner]=0, s_addr, s_wdata, s_rd and s_wr SHALL all be 0.
REQ-025 m_ready[i] SHALL equal s_ready AND m_ack[i]; non-owners SHALL see 0.
REQ-026 m_rdata SHALL be s_rdata passed through combinationally, with no register.
REQ-027 Simultaneous requests SHALL be resolved by the round-robin order alone; no master has fixed priority.
REQ-028 The arbiter SHALL NOT check or count beats; transaction length is defined solely by m_req.
REQ-029 Requests SHALL NOT be queued: a master that deasserts m_req before being granted is forgotten.
REQ-030 A strobe from a non-owner SHALL be ignored and SHALL NOT reach the slave.

Reset
REQ-031 While rst_b=0: state=IDLE, owner=0, last_owner=NMASTERS-1, so master 0 wins first.
REQ-031a While rst_b=0, all outputs SHALL be 0 regardless of clk.
REQ-032 Reset asserted mid-transaction SHALL drop m_ack and all slave strobes immediately, without waiting for a clock edge.
REQ-033 After rst_b rises, arbitration SHALL resume per REQ-019 at the first clock edge.

Verification
REQ-034 Single master: m_req=0010 at cycle 0 -> m_ack=0010 from cycle 1; s_addr equals m_addr[1]; m_ready[1] follows s_ready; m_req drops at cycle 20 -> m_ack=0000 at cycle 21.
REQ-035 Contention after reset: m_req=0011 -> master 0 granted first; master 0 releases -> m_ack=0010 at the next edge, with no IDLE cycle in between.
REQ-036 Fairness: all four masters requesting continuously, each releasing after 3 cycles -> grant order 0,1,2,3,0; each master is granted within 4 transactions.
REQ-037 16-beat read fill: DCache holds m_req for 16 s_ready beats while ICache also requests -> no grant switch occurs until the DCache drops m_req; m_ready[0] stays 0 throughout.
REQ-038 Reset mid-fill: rst_b falls at beat 7 -> m_ack=0 and s_rd=0 within the same cycle; after release, master 0 is granted first.
REQ-039 Isolation: a non-owner pulses m_wr=1 with m_wdata=DEADBEEF -> s_wr and s_wdata remain the owner's values.
